// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of a 5-stage MIPS-style core.
// Registers the EX->MEM bus, aligns/extends synchronous SRAM load data and
// builds the MEM->WB bus plus the MEM->RF forwarding bus.
// Optional feature macro: MEM_FWD_EN (when undefined, mem_to_rf_bus is zero).
module mem_stage #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [144:0]       ex_to_mem_bus,
    input  logic [31:0]        data_sram_rdata,
    output logic [135:0]       mem_to_wb_bus,
    output logic [103:0]       mem_to_rf_bus
);

    // Field layout of the EX->MEM bus, MSB first.
    typedef struct packed {
        logic [65:0] hilo_bus;      // {hi_we, lo_we, hi, lo}
        logic [2:0]  mem_op;
        logic [31:0] ex_pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100
    } mem_op_e;

    ex_mem_t     ex_to_mem_bus_r;
    logic        bubble;
    logic        hold;
    logic [1:0]  offset;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        use_load;
    logic [31:0] rf_wdata;

    // Only stall[3] (MEM) and stall[4] (WB) matter here; other stage bits are ignored.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign bubble = stall[3] && !stall[4];
    assign hold   = stall[3];

    // Pipeline register: reset, then bubble, then load, otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
        end else if (bubble) begin
            ex_to_mem_bus_r <= '0;
        end else if (!hold) begin
            ex_to_mem_bus_r <= ex_to_mem_bus;
        end
    end

    // Misaligned halfword/word addresses are not trapped; low bits just select lanes.
    assign offset = ex_to_mem_bus_r.ex_result[1:0];

    // Lane selection and sign/zero extension of the SRAM read word.
    // NOTE: every variable gets a default at the top of the combinational
    // block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_byte = data_sram_rdata[7:0];
        load_half = data_sram_rdata[15:0];
        load_data = data_sram_rdata;
        case (offset)
            2'd1:    load_byte = data_sram_rdata[15:8];
            2'd2:    load_byte = data_sram_rdata[23:16];
            2'd3:    load_byte = data_sram_rdata[31:24];
            default: load_byte = data_sram_rdata[7:0];
        endcase
        if (offset[1]) begin
            load_half = data_sram_rdata[31:16];
        end
        case (ex_to_mem_bus_r.mem_op)
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h0, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0, load_half};
            default: load_data = data_sram_rdata;    // lw and unused encodings
        endcase
    end

    // A store never returns memory data, whatever sel_rf_res says.
    assign use_load = ex_to_mem_bus_r.sel_rf_res &&
                      ex_to_mem_bus_r.data_ram_en &&
                      (ex_to_mem_bus_r.data_ram_wen == 4'b0000);

    assign rf_wdata = use_load ? load_data : ex_to_mem_bus_r.ex_result;

    assign mem_to_wb_bus = {ex_to_mem_bus_r.hilo_bus,
                            ex_to_mem_bus_r.ex_pc,
                            ex_to_mem_bus_r.rf_we,
                            ex_to_mem_bus_r.rf_waddr,
                            rf_wdata};

`ifdef MEM_FWD_EN
    assign mem_to_rf_bus = {ex_to_mem_bus_r.hilo_bus,
                            ex_to_mem_bus_r.rf_we,
                            ex_to_mem_bus_r.rf_waddr,
                            rf_wdata};
`else
    assign mem_to_rf_bus = '0;
`endif

endmodule
